// File: rtl/ex_wb_stage_pkg.sv
// ex_wb_stage_pkg
// Shared widths and ALU opcode encodings for the 8-bit pipelined core.
// The ID stage uses the same opcode constants when it fills EX_ALUop.
package ex_wb_stage_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [OP_W-1:0] ALU_XOR = 4'd4;
  localparam logic [OP_W-1:0] ALU_NOT = 4'd5;
  localparam logic [OP_W-1:0] ALU_SHL = 4'd6;
  localparam logic [OP_W-1:0] ALU_SHR = 4'd7;
  localparam logic [OP_W-1:0] ALU_MOV = 4'd8;

endpackage

// File: rtl/ex_wb_stage_alu8.sv
// alu8
// Purely combinational ALU for the execute stage.
// Ports:
//   a  - operand A (register or forwarded value)
//   b  - operand B (immediate)
//   op - operation select (ALU_* encodings)
//   r  - result, wraps modulo 2**DATA_W
//   c  - carry (ADD), borrow (SUB), shifted-out bit (SHL/SHR), else 0
module alu8
  import ex_wb_stage_pkg::*;
#(
  parameter int DATA_W = ex_wb_stage_pkg::DATA_W,
  parameter int OP_W   = ex_wb_stage_pkg::OP_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] r,
  output logic              c
);

  // One extra bit so ADD carry-out and SUB borrow fall out of the same adder.
  logic [DATA_W:0] sum;

  always_comb begin
    sum = '0;
    r   = a;
    c   = 1'b0;
    case (op)
      ALU_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[DATA_W-1:0];
        c   = sum[DATA_W];
      end
      ALU_SUB: begin
        // Top bit of the widened difference is set exactly when a < b.
        sum = {1'b0, a} - {1'b0, b};
        r   = sum[DATA_W-1:0];
        c   = sum[DATA_W];
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOT: r = ~a;
      ALU_SHL: begin
        r = {a[DATA_W-2:0], 1'b0};
        c = a[DATA_W-1];
      end
      ALU_SHR: begin
        r = {1'b0, a[DATA_W-1:1]};
        c = a[0];
      end
      // MOV and the reserved encodings pass A through with carry clear.
      default: begin
        r = a;
        c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// ex_wb_stage
// Execute stage plus EX/WB pipeline register of the 8-bit core.
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-low reset
//   EX_instr            - instruction; [REG_AW-1:0] is source register rs
//   EX_ALUop            - ALU operation select
//   EX_RegWrite         - instruction writes a register
//   EX_LoadImmediate    - result is EX_ImmediateData, ALU bypassed
//   EX_RegData1         - register-file value of rs read in ID
//   EX_writeReg         - destination register rd
//   EX_ImmediateData    - immediate operand (ALU operand B)
//   EX_flush            - squash the current instruction into a bubble
//   WB_RegWrite/writeReg/result/instr - registered writeback bundle
//   WB_zero, WB_carry   - flags, updated only by ALU register writes
//   fwd_hit             - combinational: operand A taken from WB_result
module ex_wb_stage
  import ex_wb_stage_pkg::*;
#(
  parameter int DATA_W = ex_wb_stage_pkg::DATA_W,
  parameter int REG_AW = ex_wb_stage_pkg::REG_AW,
  parameter int OP_W   = ex_wb_stage_pkg::OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] EX_instr,
  input  logic [OP_W-1:0]   EX_ALUop,
  input  logic              EX_RegWrite,
  input  logic              EX_LoadImmediate,
  input  logic [DATA_W-1:0] EX_RegData1,
  input  logic [REG_AW-1:0] EX_writeReg,
  input  logic [DATA_W-1:0] EX_ImmediateData,
  input  logic              EX_flush,
  output logic              WB_RegWrite,
  output logic [REG_AW-1:0] WB_writeReg,
  output logic [DATA_W-1:0] WB_result,
  output logic [DATA_W-1:0] WB_instr,
  output logic              WB_zero,
  output logic              WB_carry,
  output logic              fwd_hit
);

  logic [DATA_W-1:0] opa_p0;
  logic [DATA_W-1:0] alu_r_p0;
  logic              alu_c_p0;
  logic [DATA_W-1:0] res_p0;
  logic              flag_upd_p0;

  // ---- Stage p0: execute (forwarding, ALU, result select) ----
  // Only the immediately previous instruction can be forwarded; older results
  // are already visible through the register file's first-half-cycle write.
  // A flushed or reset WB slot has WB_RegWrite=0 and therefore never matches.
  assign fwd_hit = WB_RegWrite && (WB_writeReg == EX_instr[REG_AW-1:0]);
  assign opa_p0  = fwd_hit ? WB_result : EX_RegData1;

  alu8 #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .a  (opa_p0),
    .b  (EX_ImmediateData),
    .op (EX_ALUop),
    .r  (alu_r_p0),
    .c  (alu_c_p0)
  );

  assign res_p0      = EX_LoadImmediate ? EX_ImmediateData : alu_r_p0;
  // Flags track ALU results that are actually written back; load-immediates,
  // bubbles and flushed instructions leave them untouched.
  assign flag_upd_p0 = !EX_flush && EX_RegWrite && !EX_LoadImmediate;

  // ---- Stage p1: EX/WB register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_RegWrite <= 1'b0;
      WB_writeReg <= '0;
      WB_result   <= '0;
      WB_instr    <= '0;
      WB_zero     <= 1'b0;
      WB_carry    <= 1'b0;
    end else begin
      if (EX_flush) begin
        WB_RegWrite <= 1'b0;
        WB_writeReg <= '0;
        WB_result   <= '0;
        WB_instr    <= '0;
      end else begin
        WB_RegWrite <= EX_RegWrite;
        WB_writeReg <= EX_writeReg;
        WB_result   <= res_p0;
        WB_instr    <= EX_instr;
      end
      if (flag_upd_p0) begin
        WB_zero  <= (res_p0 == '0);
        WB_carry <= alu_c_p0;
      end
    end
  end

endmodule
